memmap_prog: RTL
================

Name: memmap_prog

Overview:
- Programmable successor to the fixed physical-address chip-select decoder.
- Sits between the MMU physical address output and the device chip selects.
- Decodes against a run-time-writable table of NREGIONS base/mask entries instead of a hard-wired map.
- Tracks each access with a watchdog: drives a bus error for unmapped addresses and for devices that never acknowledge.

Parameters:
- AHI, 27, MSB of decoded physical address field
- ALO, 20, LSB of decoded physical address field; DW = AHI-ALO+1
- NREGIONS, 8, number of table entries / chip-select outputs (2..16); IW = $clog2(NREGIONS)
- TIMEOUT, 255, clk cycles in ACTIVE without ack_in before bus error (1..65535); counter width 16
- BOOT_BASE, 8'b01000000, reset base of entry 0 (ROM), width DW
- BOOT_MASK, 8'b11000000, reset mask of entry 0, width DW

Ports:
- clk  input  1  system clock (50MHz), all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  access strobe; when low, all outputs forced low combinationally
- addr_in  input  [AHI:ALO]  physical address field
- rw_in  input  1  1=read, 0=write
- ack_in  input  1  device acknowledge (DTACK-equivalent)
- cfg_we  input  1  table write strobe, single cycle
- cfg_idx  input  IW  entry index
- cfg_base  input  DW  entry base
- cfg_mask  input  DW  entry mask (1 = bit compared)
- cfg_valid  input  1  entry valid
- cfg_wp  input  1  entry write-protect (see Optional Feature)
- cs  output  NREGIONS  one-hot chip selects
- csunmap  output  1  unmapped-access indicator
- berr  output  1  bus error to CPU
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; cs=0, csunmap=0, berr=0, busy=0; timeout counter=0.
- Reset table: entry 0 = {BOOT_BASE, BOOT_MASK, valid=1, wp=0}; all other entries valid=0, base=0, mask=0, wp=0.
- Match: entry i hits when valid_i && ((addr_in ^ base_i) & mask_i) == 0. Lowest index wins; mask=0 with valid=1 matches everything.
- Table write: on the clk edge with cfg_we=1, entry cfg_idx is updated.
  - cfg_idx >= NREGIONS: write ignored.
  - The decode on the same edge uses the pre-write table.
- FSM states: IDLE, ACTIVE, DONE, ERROR.
- IDLE, enable=1 at an edge: decode registered on that edge, outputs valid 1 cycle after enable is sampled.
  - Hit: go to ACTIVE, cs[i]=1, counter cleared.
  - Miss: go to ERROR, csunmap=1, berr=1.
- ACTIVE:
  - ack_in=1: go to DONE; cs held.
  - Otherwise counter increments. On the edge where counter reaches TIMEOUT-1 with no ack: go to ERROR, cs=0, berr=1, csunmap=0.
  - ack_in on the same edge as expiry: ack wins (DONE).
- DONE / ERROR: registered outputs held until enable=0.
- enable=0 sampled in any state: next edge goes to IDLE, all registered outputs cleared, counter cleared. Outputs are already low combinationally.
- Address/table changes while not in IDLE do not alter cs; the decode is latched.
- busy = (state != IDLE), not gated by enable.
- At most one of cs bits / csunmap is high at any time; berr is never high together with any cs bit.

Optional Feature:
- Macro: MEMMAP_WPROT_EN
- Defined: per-entry wp bit stored. A hit with rw_in=0 on an entry with wp=1 goes to ERROR with berr=1, cs=0, csunmap=0, with the same one-cycle latency as a miss.
- Undefined: cfg_wp and rw_in ports exist but are ignored; no wp storage is synthesised; writes decode identically to reads.

Test Plan:
- Post-reset read, addr_in=8'h40, ack_in high 3 cycles after cs → cs=8'b00000001 one cycle after enable; DONE holds cs until enable drops; berr never set.
- Program entry 3 {base 8'h80, mask 8'hC0, valid}; access 8'h85 → cs[3]=1; access 8'h05 → csunmap=1, berr=1 one cycle after enable, cs=0.
- Entries 1 and 2 both matching 8'hC2 → only cs[1]. Then invalidate entry 1 → next access gives cs[2].
- TIMEOUT=4, hit with no ack_in → cs high 4 cycles, then cs=0, berr=1 until enable low. Repeat with ack_in on the expiry cycle → DONE, no berr.
- rst_n asserted mid-ACTIVE → all outputs 0 immediately (asynchronous). Table returns to boot state: prior entry-3 programming lost, 8'h85 now unmapped.
- With MEMMAP_WPROT_EN: entry 0 wp=1, write (rw_in=0) to 8'h40 → berr=1, cs=0. Read to 8'h40 → cs[0]=1. Without the macro, the same write gives cs[0]=1.

Source files
------------

// File: rtl/memmap_prog.sv
// memmap_prog: programmable physical-address chip-select decoder.
// NREGIONS base/mask entries are writable at run time; each access is tracked
// by a watchdog FSM that raises berr for unmapped addresses or missing acks.
// Optional feature: define MEMMAP_WPROT_EN to store a per-entry write-protect
// bit; a write hitting a protected entry then ends in a bus error.

// One decode table entry: base/mask/valid storage plus its match compare.
module memmap_entry #(
  parameter int             DW        = 8,
  parameter int             IW        = 3,
  parameter int             IDX       = 0,
  parameter logic [DW-1:0]  RST_BASE  = '0,
  parameter logic [DW-1:0]  RST_MASK  = '0,
  parameter logic           RST_VALID = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] addr,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [DW-1:0] cfg_base,
  input  logic [DW-1:0] cfg_mask,
  input  logic          cfg_valid,
  output logic          hit
);
  logic [DW-1:0] base, mask;
  logic          valid;

  // Entry storage; an index outside the table simply matches no entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base  <= RST_BASE;
      mask  <= RST_MASK;
      valid <= RST_VALID;
    end else if (cfg_we && cfg_idx == IW'(IDX)) begin
      base  <= cfg_base;
      mask  <= cfg_mask;
      valid <= cfg_valid;
    end
  end

  assign hit = valid && (((addr ^ base) & mask) == '0);
endmodule

module memmap_prog #(
  parameter int AHI      = 27,
  parameter int ALO      = 20,
  parameter int NREGIONS = 8,
  parameter int TIMEOUT  = 255,
  parameter logic [AHI-ALO:0] BOOT_BASE = 8'b01000000,
  parameter logic [AHI-ALO:0] BOOT_MASK = 8'b11000000,
  localparam int DW = AHI - ALO + 1,
  localparam int IW = $clog2(NREGIONS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [AHI:ALO]      addr_in,
  input  logic                rw_in,
  input  logic                ack_in,
  input  logic                cfg_we,
  input  logic [IW-1:0]       cfg_idx,
  input  logic [DW-1:0]       cfg_base,
  input  logic [DW-1:0]       cfg_mask,
  input  logic                cfg_valid,
  input  logic                cfg_wp,
  output logic [NREGIONS-1:0] cs,
  output logic                csunmap,
  output logic                berr,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, ERROR} state_t;

  state_t                state;
  logic [NREGIONS-1:0]   hit, sel, cs_q;
  logic                  unmap_q, berr_q, wp_hit;
  logic [15:0]           cnt;

  for (genvar g = 0; g < NREGIONS; g++) begin : g_ent
    memmap_entry #(
      .DW(DW), .IW(IW), .IDX(g),
      .RST_BASE((g == 0) ? BOOT_BASE : '0),
      .RST_MASK((g == 0) ? BOOT_MASK : '0),
      .RST_VALID(g == 0)
    ) u_ent (
      .clk(clk), .rst_n(rst_n), .addr(addr_in),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base),
      .cfg_mask(cfg_mask), .cfg_valid(cfg_valid), .hit(hit[g])
    );
  end

  // Lowest-index hit wins: isolate the least significant set bit.
  assign sel = hit & (~hit + NREGIONS'(1));

`ifdef MEMMAP_WPROT_EN
  logic [NREGIONS-1:0] wp_q;

  // Write-protect bits, written alongside the table entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NREGIONS; i++)
        if (cfg_idx == IW'(i)) wp_q[i] <= cfg_wp;
    end
  end

  assign wp_hit = ~rw_in & |(sel & wp_q);
`else
  logic unused_wp;
  assign unused_wp = ^{cfg_wp, rw_in};
  assign wp_hit    = 1'b0;
`endif

  // Access FSM: latch decode on entry, watch for ack or timeout, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cs_q    <= '0;
      unmap_q <= 1'b0;
      berr_q  <= 1'b0;
      cnt     <= '0;
    end else if (!enable) begin
      state   <= IDLE;
      cs_q    <= '0;
      unmap_q <= 1'b0;
      berr_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (hit == '0) begin
            state   <= ERROR;
            unmap_q <= 1'b1;
            berr_q  <= 1'b1;
          end else if (wp_hit) begin
            state  <= ERROR;
            berr_q <= 1'b1;
          end else begin
            state <= ACTIVE;
            cs_q  <= sel;
          end
        end
        ACTIVE: begin
          if (ack_in) begin
            state <= DONE;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            state  <= ERROR;
            cs_q   <= '0;
            berr_q <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cs      = cs_q & {NREGIONS{enable}};
  assign csunmap = unmap_q & enable;
  assign berr    = berr_q & enable;
  assign busy    = (state != IDLE);
endmodule
